// File: rtl/dc_dac_spi_writer.sv
// Purpose: takes one dispatcher frame and sends payload words 1..FRAME_WORDS-1 over SPI mode 0 to the selected DAC, then pulses the shared LDAC.
// Latency: 1 + (FRAME_WORDS-1)*((1+2*SPI_BITS)*CLK_DIV + CS_GAP) + LDAC_WIDTH cycles from the acceptance edge to o_frame_done.
// Backpressure: none upstream; a strobe while busy or with an out-of-range channel is discarded and flagged on o_drop.
module dc_dac_spi_writer #(
  parameter int DAC_CHANNEL = 24,
  parameter int FRAME_WORDS = 62,
  parameter int SPI_BITS    = 24,
  parameter int CLK_DIV     = 4,
  parameter int CS_GAP      = 2,
  parameter int LDAC_WIDTH  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [FRAME_WORDS-1:0][31:0] i_dc_regs,
  input  logic [4:0]                   i_channel_sel,
  input  logic                         i_valid_frame,
  output logic                         o_spi_sclk,
  output logic                         o_spi_mosi,
  output logic [DAC_CHANNEL-1:0]       o_spi_cs_n,
  output logic                         o_ldac_n,
  output logic                         o_busy,
  output logic [5:0]                   o_word_idx,
  output logic                         o_frame_done,
  output logic                         o_drop
);

  localparam int BIT_W   = (SPI_BITS > 1) ? $clog2(SPI_BITS) : 1;
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int TMR_MAX = (CS_GAP > LDAC_WIDTH) ? CS_GAP : LDAC_WIDTH;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PAY_W   = (FRAME_WORDS - 1) * SPI_BITS;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SPI_BITS - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] LDAC_LAST = TMR_W'(LDAC_WIDTH - 1);

  // ST_LOAD is the acceptance cycle: the frame is latched, chip select is not yet driven.
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_CS_SETUP, ST_SHIFT, ST_GAP, ST_LDAC, ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic [DAC_CHANNEL-1:0] cs_n_q, cs_n_d;
  logic [DAC_CHANNEL-1:0] mask_q, mask_d;
  logic                   ldac_n_q, ldac_n_d;
  logic                   busy_q, busy_d;
  logic [5:0]             word_idx_q, word_idx_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [SPI_BITS-1:0]    sh_q, sh_d;
  logic [PAY_W-1:0]       pay_q, pay_d;

  logic [PAY_W-1:0]       payload_in;
  logic [SPI_BITS-1:0]    sh_next;
  logic                   load_word;
  logic                   chan_ok;
  logic                   unused_dc_bits;

  // Header word and the bits above SPI_BITS never reach the wire.
  assign unused_dc_bits = ^i_dc_regs;
  assign chan_ok        = int'(i_channel_sel) < DAC_CHANNEL;

  // Pack payload words back to back, word 1 in the least significant slot so words pop off by right shift.
  always_comb begin
    payload_in = '0;
    for (int w = 1; w < FRAME_WORDS; w++) begin
      payload_in[(w-1)*SPI_BITS +: SPI_BITS] = i_dc_regs[w][SPI_BITS-1:0];
    end
  end

  // Next-state and next-output computation for the whole transfer sequencer.
  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    mask_d     = mask_q;
    ldac_n_d   = ldac_n_q;
    busy_d     = busy_q;
    word_idx_d = word_idx_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    div_d      = div_q;
    bit_d      = bit_q;
    tmr_d      = tmr_q;
    sh_d       = sh_q;
    pay_d      = pay_q;
    load_word  = 1'b0;
    sh_next    = sh_q << 1;

    if (i_valid_frame && (state_q != ST_IDLE)) drop_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid_frame) begin
          if (chan_ok) begin
            busy_d  = 1'b1;
            pay_d   = payload_in;
            mask_d  = ~(DAC_CHANNEL'(1) << i_channel_sel);
            state_d = ST_LOAD;
          end else begin
            drop_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        word_idx_d = 6'd1;
        load_word  = 1'b1;
      end
      ST_CS_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d   = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit while the DAC is not sampling.
            sclk_d = 1'b0;
            sh_d   = sh_next;
            mosi_d = sh_next[SPI_BITS-1];
          end else if (bit_q == BIT_LAST) begin
            // The last low phase has served as CS hold time.
            state_d = ST_GAP;
            cs_n_d  = '1;
            mosi_d  = 1'b0;
            tmr_d   = '0;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sclk_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          if (int'(word_idx_q) < FRAME_WORDS - 1) begin
            word_idx_d = word_idx_q + 6'd1;
            load_word  = 1'b1;
          end else begin
            state_d  = ST_LDAC;
            ldac_n_d = 1'b0;
            tmr_d    = '0;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_LDAC: begin
        if (tmr_q == LDAC_LAST) begin
          state_d  = ST_DONE;
          ldac_n_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        word_idx_d = 6'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start of a word: assert chip select and put its MSB on MOSI.
    if (load_word) begin
      state_d = ST_CS_SETUP;
      cs_n_d  = mask_q;
      sclk_d  = 1'b0;
      div_d   = '0;
      sh_d    = pay_q[SPI_BITS-1:0];
      mosi_d  = pay_q[SPI_BITS-1];
      pay_d   = pay_q >> SPI_BITS;
    end
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      mask_q     <= '1;
      ldac_n_q   <= 1'b1;
      busy_q     <= 1'b0;
      word_idx_q <= 6'd0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      tmr_q      <= '0;
      sh_q       <= '0;
      pay_q      <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      mask_q     <= mask_d;
      ldac_n_q   <= ldac_n_d;
      busy_q     <= busy_d;
      word_idx_q <= word_idx_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tmr_q      <= tmr_d;
      sh_q       <= sh_d;
      pay_q      <= pay_d;
    end
  end

  assign o_spi_sclk   = sclk_q;
  assign o_spi_mosi   = mosi_q;
  assign o_spi_cs_n   = cs_n_q;
  assign o_ldac_n     = ldac_n_q;
  assign o_busy       = busy_q;
  assign o_word_idx   = word_idx_q;
  assign o_frame_done = done_q;
  assign o_drop       = drop_q;

endmodule

// File: doc/dc_dac_spi_writer.md
Name: dc_dac_spi_writer

Overview:
- Downstream consumer of the DC frame dispatcher's frame/channel outputs.
- On each valid-frame strobe it latches the frame and serialises payload words 1..FRAME_WORDS-1 as SPI_BITS-bit DAC writes to the one DAC selected by the channel index.
- After the last word it pulses a shared LDAC strobe so all writes take effect together.
- Sits between the dispatcher and the board-level DAC SPI pins.

Parameters:
- DAC_CHANNEL, 24, number of DAC chips, one chip select each.
- FRAME_WORDS, 62, words per frame; word 0 is the header and is not transmitted.
- SPI_BITS, 24, bits shifted per payload word, taken from bits [SPI_BITS-1:0] MSB first; bits [31:SPI_BITS] are ignored.
- CLK_DIV, 4, i_clk cycles per SCLK half-period; must be >= 1.
- CS_GAP, 2, i_clk cycles chip select stays high between consecutive words; must be >= 1.
- LDAC_WIDTH, 4, i_clk cycles o_ldac_n is held low after the last word; must be >= 1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_dc_regs  in  FRAME_WORDS x 32  frame words from the dispatcher; sampled only on an accepted i_valid_frame.
- i_channel_sel  in  5  target DAC index; sampled with i_dc_regs.
- i_valid_frame  in  1  one-cycle frame-ready strobe.
- o_spi_sclk  out  1  SPI clock, idles low.
- o_spi_mosi  out  1  SPI data.
- o_spi_cs_n  out  DAC_CHANNEL  active-low chip selects; at most one bit low at any time.
- o_ldac_n  out  1  active-low shared load-DAC strobe.
- o_busy  out  1  high from frame acceptance until the o_frame_done cycle, inclusive.
- o_word_idx  out  6  index of the payload word currently being sent, range 1..FRAME_WORDS-1; 0 when idle.
- o_frame_done  out  1  one-cycle pulse when a frame completes.
- o_drop  out  1  one-cycle pulse when a strobed frame is rejected.

Behaviour:
- Reset: i_rst is sampled on the i_clk edge and takes effect at the same edge, from any state.
  - Reset values: state IDLE, o_spi_sclk=0, o_spi_mosi=0, o_spi_cs_n=all 1, o_ldac_n=1, o_busy=0, o_word_idx=0, o_frame_done=0, o_drop=0.
  - Reset mid-transfer aborts the frame with no LDAC pulse and no o_frame_done.
- All outputs are registered.
- Frame acceptance: i_valid_frame is accepted only in IDLE with i_channel_sel < DAC_CHANNEL.
  - On acceptance, latch i_dc_regs[1..FRAME_WORDS-1] and i_channel_sel, and set o_busy=1 at the next edge.
  - i_valid_frame while busy: o_drop=1 on the next cycle; the in-flight frame is unaffected.
  - i_valid_frame in IDLE with i_channel_sel >= DAC_CHANNEL: o_drop=1 on the next cycle and the block stays IDLE.
- States: IDLE -> CS_SETUP -> SHIFT -> GAP -> (CS_SETUP for the next word | LDAC) -> DONE -> IDLE.
- CS_SETUP (CLK_DIV cycles):
  - o_spi_cs_n[sel]=0, o_spi_sclk=0, o_spi_mosi = bit SPI_BITS-1 of the current word.
  - Entered on the cycle after acceptance, with o_word_idx=1.
- SHIFT: for each bit, SCLK high for CLK_DIV cycles, then SCLK low for CLK_DIV cycles (SPI mode 0: DAC samples on the rising edge).
  - MOSI advances to the next bit on the same edge SCLK falls.
  - After the last bit's low phase, which doubles as the CS hold, go to GAP.
  - CS low duration per word = (1 + 2*SPI_BITS)*CLK_DIV cycles.
- GAP: all o_spi_cs_n high, o_spi_mosi=0, for CS_GAP cycles.
  - If o_word_idx < FRAME_WORDS-1: increment o_word_idx and go to CS_SETUP.
  - Otherwise go to LDAC.
- LDAC: o_ldac_n=0 for LDAC_WIDTH cycles, then DONE.
- DONE: one cycle with o_frame_done=1 and o_busy=1. At the next edge enter IDLE with o_busy=0 and o_word_idx=0.
  - A new frame strobe is accepted in the first IDLE cycle.
- Total frame latency, from the acceptance edge to o_frame_done high: 1 + (FRAME_WORDS-1)*((1+2*SPI_BITS)*CLK_DIV + CS_GAP) + LDAC_WIDTH cycles.
- Counters: bit counter ceil(log2(SPI_BITS)) bits, divider counter ceil(log2(CLK_DIV+1)) bits. Neither counter wraps outside its defined range.

Test Plan:
- Reset during SHIFT: with FRAME_WORDS=3, CLK_DIV=2, assert i_rst mid-word -> the next cycle shows cs_n all 1, sclk 0, ldac_n 1, busy 0; no frame_done. A strobe after reset is accepted normally.
- Single frame: FRAME_WORDS=3, SPI_BITS=24, CLK_DIV=2, CS_GAP=2, LDAC_WIDTH=4, sel=5, words 1,2 = 0xFFA5_5A3C and 0x0012_3456.
  - Required: only cs_n[5] toggles; MOSI captured on rising SCLK = 0xA55A3C then 0x123456; exactly 24 rising edges per word.
  - Required: cs low 98 cycles, gap 2 cycles, ldac_n low 4 cycles; frame_done at cycle 1+2*100+4=205 after acceptance.
- Busy drop: a second strobe 50 cycles into a frame -> o_drop one cycle later; the original frame completes unchanged with one frame_done.
- Bad channel: strobe with sel=24 (DAC_CHANNEL=24) -> o_drop pulse, busy stays 0, all cs_n stay 1.
- Back-to-back: a strobe in the first IDLE cycle after frame_done -> accepted, with no drop pulse. o_word_idx sequence is 1,2 for each frame, and 0 between frames.
- Full size: defaults (62 words, CLK_DIV=4), sel=23 -> 61 words sent with cs_n[23] only; frame_done at 1+61*198+4=12083 cycles after acceptance.
